// File: rtl/pipeline_ctrl_pkg.sv
// pipeline_ctrl_pkg: shared state, register and ALUOp definitions for the pipeline control slice
package pipeline_ctrl_pkg;
    typedef enum logic [1:0] {RUN, MEM_WAIT, FAULT} state_e;
    typedef enum logic [1:0] {
        ALUOP_LDST   = 2'b00,
        ALUOP_BRANCH = 2'b01,
        ALUOP_RTYPE  = 2'b10,
        ALUOP_IMM    = 2'b11
    } aluop_e;
    localparam int REG_ZERO = 0;
    localparam int WAIT_W   = 8;
endpackage

// File: rtl/load_use_detect.sv
// load_use_detect: flags an ID instruction reading the destination of a load still in EX
module load_use_detect
    import pipeline_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_rt,
    output logic                  lu
);
    assign lu = ex_mem_read && (ex_rt != REG_ADDR_W'(REG_ZERO)) && (ex_rt == id_rs || ex_rt == id_rt);
endmodule

// File: rtl/pipeline_stall_ctrl.sv
// pipeline_stall_ctrl: hazard/stall sequencer; define STALL_PERF_CNT_EN to build the stall counter
module pipeline_stall_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W  = 5,
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_rt,
    input  logic                  ex_branch_taken,
    input  logic                  mem_req,
    input  logic                  dmem_ack,
    output logic                  pc_write,
    output logic                  ifid_write,
    output logic                  idex_bubble,
    output logic                  ifid_flush,
    output logic                  idex_flush,
    output logic                  pipe_hold,
    output logic                  dmem_timeout,
    output logic [CNT_W-1:0]      stall_cnt
);
    localparam logic [WAIT_W-1:0] TIMEOUT_V = WAIT_W'(MEM_TIMEOUT);

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d, wait_inc;
    logic              timeout_q, timeout_d;
    logic              lu, freeze;

    load_use_detect #(.REG_ADDR_W(REG_ADDR_W)) u_lu (
        .id_rs(id_rs),
        .id_rt(id_rt),
        .ex_mem_read(ex_mem_read),
        .ex_rt(ex_rt),
        .lu(lu)
    );

    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        timeout_d   = timeout_q;
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        idex_bubble = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        pipe_hold   = 1'b0;
        freeze      = (state_q == FAULT) || (!dmem_ack && (state_q == MEM_WAIT || mem_req));
        wait_inc    = (state_q == RUN) ? WAIT_W'(1) : wait_q + WAIT_W'(1);
        if (freeze) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            pipe_hold  = 1'b1;
        end else if (ex_branch_taken) begin
            ifid_write = 1'b0;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (lu) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
        end
        // the counter includes the RUN cycle that first saw the unacknowledged request
        if (state_q != FAULT && freeze) begin
            wait_d    = wait_inc;
            timeout_d = wait_inc >= TIMEOUT_V;
            state_d   = (wait_inc >= TIMEOUT_V) ? FAULT : MEM_WAIT;
        end else if (state_q != FAULT) begin
            wait_d  = '0;
            state_d = RUN;
        end
        if (!rst_n) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_bubble = 1'b0;
            ifid_flush = 1'b0;
            idex_flush = 1'b0;
            pipe_hold  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= RUN;
            wait_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            timeout_q <= timeout_d;
        end
    end

    assign dmem_timeout = timeout_q;

`ifdef STALL_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = (!pc_write && stall_cnt_q != '1) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = '0;
`endif
endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// tb_pipeline_stall_ctrl: directed and random stimulus against a behavioural model of the stall sequencer
module tb_pipeline_stall_ctrl;
    localparam int AW = 5;
    localparam int TO = 15;
    localparam int CW = 4;
`ifdef STALL_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] id_rs = '0, id_rt = '0, ex_rt = '0;
    logic          ex_mem_read = 1'b0, ex_branch_taken = 1'b0, mem_req = 1'b0, dmem_ack = 1'b0;
    logic          pc_write, ifid_write, idex_bubble, ifid_flush, idex_flush, pipe_hold, dmem_timeout;
    logic [CW-1:0] stall_cnt;

    always #5 clk = ~clk;

    pipeline_stall_ctrl #(.REG_ADDR_W(AW), .MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .id_rs(id_rs),
        .id_rt(id_rt),
        .ex_mem_read(ex_mem_read),
        .ex_rt(ex_rt),
        .ex_branch_taken(ex_branch_taken),
        .mem_req(mem_req),
        .dmem_ack(dmem_ack),
        .pc_write(pc_write),
        .ifid_write(ifid_write),
        .idex_bubble(idex_bubble),
        .ifid_flush(ifid_flush),
        .idex_flush(idex_flush),
        .pipe_hold(pipe_hold),
        .dmem_timeout(dmem_timeout),
        .stall_cnt(stall_cnt)
    );

    int n_vec = 0;
    int n_err = 0;
    bit m_wait = 0, m_fault = 0;
    int m_cnt = 0, m_stall = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cyc(input logic rn, input logic mr, input logic ak, input logic br,
                       input logic emr, input logic [AW-1:0] ert, input logic [AW-1:0] rs,
                       input logic [AW-1:0] rt);
        bit lu, frz;
        logic [5:0] e;
        rst_n = rn; mem_req = mr; dmem_ack = ak; ex_branch_taken = br;
        ex_mem_read = emr; ex_rt = ert; id_rs = rs; id_rt = rt;
        lu  = emr && ert != 0 && (ert == rs || ert == rt);
        frz = m_fault || (!ak && (m_wait || mr));
        // {pc_write, ifid_write, idex_bubble, ifid_flush, idex_flush, pipe_hold}
        if (!rn)      e = 6'b000000;
        else if (frz) e = 6'b000001;
        else if (br)  e = 6'b100110;
        else if (lu)  e = 6'b001000;
        else          e = 6'b110000;
        @(negedge clk);
        check_eq("pc_write", 32'(pc_write), 32'(e[5]));
        check_eq("ifid_write", 32'(ifid_write), 32'(e[4]));
        check_eq("idex_bubble", 32'(idex_bubble), 32'(e[3]));
        check_eq("ifid_flush", 32'(ifid_flush), 32'(e[2]));
        check_eq("idex_flush", 32'(idex_flush), 32'(e[1]));
        check_eq("pipe_hold", 32'(pipe_hold), 32'(e[0]));
        check_eq("dmem_timeout", 32'(dmem_timeout), 32'(m_fault));
        check_eq("stall_cnt", 32'(stall_cnt), PERF ? 32'(m_stall) : 32'd0);
        if (!rn) begin
            m_wait = 0; m_fault = 0; m_cnt = 0; m_stall = 0;
        end else begin
            if (!e[5] && m_stall < 2**CW - 1) m_stall++;
            if (!m_fault && frz) begin
                m_cnt   = m_wait ? m_cnt + 1 : 1;
                m_fault = m_cnt >= TO;
                m_wait  = !m_fault;
            end else if (!m_fault) begin
                m_wait = 0; m_cnt = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        @(posedge clk);
        #1;
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 1, 1, 8, 8, 8);
        idle();
        cyc(1, 0, 0, 0, 1, 8, 8, 3);
        cyc(1, 0, 0, 0, 0, 8, 8, 3);
        cyc(1, 0, 0, 0, 1, 8, 3, 8);
        cyc(1, 0, 0, 0, 1, 0, 0, 0);
        cyc(1, 0, 0, 1, 1, 8, 8, 8);
        idle();
        for (int i = 0; i < 3; i++) cyc(1, 1, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 1, 0, 0, 0, 0, 0);
        idle();
        cyc(1, 1, 1, 0, 0, 0, 0, 0);
        cyc(1, 1, 1, 1, 0, 0, 0, 0);
        idle();
        for (int i = 0; i < TO + 4; i++) cyc(1, 1, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 1, 1, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 0, 0);
        idle();
        for (int i = 0; i < TO - 1; i++) cyc(1, 1, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 1, 0, 1, 4, 4, 0);
        idle();
        for (int i = 0; i < TO - 2; i++) cyc(1, 1, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 2 * TO; i++) cyc(1, 1, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        idle();
        for (int i = 0; i < 800; i++) begin
            cyc($urandom_range(0, 99) != 0, $urandom_range(0, 2) == 0,
                $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
                $urandom_range(0, 1) == 1, AW'($urandom_range(0, 3)),
                AW'($urandom_range(0, 3)), AW'($urandom_range(0, 3)));
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/pipeline_stall_ctrl.md
Name: pipeline_stall_ctrl

Overview:
Hazard and stall sequencer for the 5-stage MIPS pipeline, consuming the decoded control bits (MemRead, MemWrite, Branch) produced per stage.
- Generates PC/IF-ID write enables, ID-EX bubble insertion and IF/ID + ID/EX flushes.
- Freezes the whole pipeline while a multi-cycle data-memory access completes, using a req/ack handshake.
- Sits beside the control unit and drives the pipeline registers' enable and clear pins.

Parameters:
REG_ADDR_W, 5, register-specifier width
MEM_TIMEOUT, 15, max wait cycles for dmem_ack before fault (1..255)
CNT_W, 16, width of stall performance counter

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  synchronous active-low reset
id_rs  in  REG_ADDR_W  rs of instruction in ID
id_rt  in  REG_ADDR_W  rt of instruction in ID
ex_mem_read  in  1  MemRead of instruction in EX (load)
ex_rt  in  REG_ADDR_W  destination of load in EX
ex_branch_taken  in  1  branch in EX resolved taken
mem_req  in  1  instruction in MEM needs data memory (MemRead|MemWrite)
dmem_ack  in  1  data memory completes access this cycle
pc_write  out  1  PC load enable
ifid_write  out  1  IF/ID register enable
idex_bubble  out  1  force ID/EX control bits to zero (NOP)
ifid_flush  out  1  clear IF/ID
idex_flush  out  1  clear ID/EX
pipe_hold  out  1  hold EX/MEM and MEM/WB
dmem_timeout  out  1  sticky memory fault flag
stall_cnt  out  CNT_W  saturating count of stalled cycles

Behaviour:
- Clocking and reset:
  - Single clock.
  - Reset is synchronous and active-low (rst_n sampled on rising clk).
  - Reset state: RUN, wait counter 0, dmem_timeout 0, stall_cnt 0.
  - While rst_n=0, combinational outputs are: pc_write=0, ifid_write=0, idex_bubble=0, ifid_flush=0, idex_flush=0, pipe_hold=0.
- FSM states: RUN, MEM_WAIT, FAULT. Outputs are Mealy (state + current inputs).
- Load-use hazard: lu = ex_mem_read & (ex_rt!=0) & (ex_rt==id_rs | ex_rt==id_rt).
- "Advance" outputs (RUN with no hazard condition): pc_write=1, ifid_write=1, all others 0.
- RUN, checked in this priority order:
  1. mem_req & !dmem_ack: pc_write=0, ifid_write=0, pipe_hold=1, flushes=0, bubble=0. Next state MEM_WAIT, wait counter loaded with 1.
  2. ex_branch_taken: pc_write=1, ifid_flush=1, idex_flush=1, ifid_write=0, bubble=0. Branch overrides lu.
  3. lu: pc_write=0, ifid_write=0, idex_bubble=1. Lasts exactly one cycle; the inserted bubble clears lu naturally.
  4. Otherwise: advance outputs.
  - mem_req & dmem_ack in the same cycle is a zero-wait access: no stall; evaluate from item 2 onward.
- MEM_WAIT:
  - !dmem_ack: same frozen outputs as RUN item 1; wait counter +1.
  - When the wait counter reaches MEM_TIMEOUT without ack: next state FAULT, dmem_timeout set.
  - dmem_ack: that same cycle, outputs are computed exactly as RUN items 2-4 (branch/lu held stable by the frozen pipe). Next state RUN, wait counter cleared.
  - Ack arriving in the cycle the counter hits MEM_TIMEOUT: ack wins, no fault.
- FAULT: all outputs frozen as in MEM_WAIT; dmem_timeout=1. Exit only via reset.
- stall_cnt: +1 on every clock with pc_write=0 while rst_n=1 (includes FAULT); saturates at all-ones, never wraps.
- Reset asserted mid-wait or in FAULT: returns to RUN on that edge; a pending mem access is abandoned.

Optional Feature:
STALL_PERF_CNT_EN
- Defined: stall_cnt is implemented as above.
- Undefined: no counter register exists; stall_cnt is tied to 0.
- All other behaviour is identical in both builds.

Decomposition:
- Shared package pipeline_ctrl_pkg holds:
  - state enum (RUN, MEM_WAIT, FAULT)
  - REG_ZERO constant
  - ALUOP encodings shared with the control unit (00 load/store, 01 branch, 10 R-type, 11 immediate)
- One natural combinational sub-module: load_use_detect (id_rs, id_rt, ex_mem_read, ex_rt -> lu).

Test Plan:
- Load-use: ex_mem_read=1, ex_rt=8, id_rs=8 -> one cycle of pc_write=0, ifid_write=0, idex_bubble=1. Next cycle with ex_mem_read=0 -> advance. With ex_rt=0 -> no stall.
- Branch over load-use: ex_branch_taken=1 and lu true in the same cycle -> ifid_flush=1, idex_flush=1, pc_write=1, idex_bubble=0.
- Memory wait: mem_req=1, ack after 3 cycles -> pipe_hold=1 for 3 cycles, then advance in the ack cycle; stall_cnt=3 (feature on) or 0 (feature off).
- Zero-wait: mem_req=1, dmem_ack=1 in the same cycle -> no stall, state stays RUN.
- Timeout: mem_req=1, no ack for 15 cycles -> dmem_timeout=1, frozen outputs persist; rst_n=0 for one edge -> RUN, dmem_timeout=0, stall_cnt=0.
- Ack at limit: ack arrives in the cycle the counter reaches 15 -> returns to RUN, no fault.
